imm_gen_pipe: RTL and testbench

- Registered, handshaked immediate generator for the decode stage. Successor to the combinational 32-bit immediate selector.
- Parametrised in XLEN (32/64) and in the width of a pass-through tag.
- Adds Z (CSR uimm) and SH (shift-amount) modes, a defined zero result for R-type, and an illegal-type flag.
- Sits between fetch/decode and register-read. It uses a 2-entry skid buffer, so upstream ready does not combinationally depend on downstream ready.

---
 rtl/imm_pkg.sv | 24 ++
 rtl/imm_gen_pipe_if.sv | 31 +++
 rtl/imm_ext_comb.sv | 52 +++++
 rtl/imm_gen_pipe.sv | 120 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format codes and XLEN choices.
package imm_pkg;

  localparam int IMM_FMT_W = 3;

  typedef enum logic [IMM_FMT_W-1:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_R  = 3'd5,
    IMM_Z  = 3'd6,
    IMM_SH = 3'd7
  } imm_fmt_e;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  function automatic logic xlen_legal(input int xlen);
    return (xlen == XLEN_32) || (xlen == XLEN_64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between decode (upstream), the immediate stage and register-read.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [IMM_FMT_W-1:0] in_type;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_imm;
  logic [31:0]          out_instr;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_illegal;

  // Driver side: produces instructions and consumes results.
  modport master (
    output in_valid, in_instr, in_type, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_instr, out_tag, out_illegal
  );

  // Stage side.
  modport slave (
    input  in_valid, in_instr, in_type, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_instr, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_ext_comb.sv
// Combinational immediate decode: instruction word + format -> XLEN immediate.
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr_i,
  input  logic [IMM_FMT_W-1:0] type_i,
  output logic [XLEN-1:0]      imm_o,
  output logic                 illegal_o
);

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr_i[6:0];

  // Sign-extend a 32-bit value to XLEN (XLEN >= 32 always holds).
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  // Select and extend the immediate field for the requested format.
  always_comb begin
    imm_o     = {XLEN{1'b0}};
    illegal_o = 1'b0;
    case (type_i)
      IMM_I:  imm_o = sext32({{20{instr_i[31]}}, instr_i[31:20]});
      IMM_S:  imm_o = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
      IMM_B:  imm_o = sext32({{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0});
      IMM_U:  imm_o = sext32({instr_i[31:12], 12'h000});
      IMM_J:  imm_o = sext32({{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0});
      IMM_R:  imm_o = {XLEN{1'b0}};
      IMM_Z:  imm_o = {{(XLEN-5){1'b0}}, instr_i[19:15]};
      IMM_SH: begin
        // A 6-bit shift amount only exists on 64-bit machines.
        if ((XLEN == XLEN_32) && instr_i[25]) begin
          illegal_o = 1'b1;
          imm_o     = {XLEN{1'b0}};
        end else begin
          imm_o     = {{(XLEN-6){1'b0}}, instr_i[25:20]};
        end
      end
      default: begin
        illegal_o = 1'b1;
        imm_o     = {XLEN{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  logic [XLEN-1:0] new_imm_s;
  logic            new_ill_s;
  logic            accept_s;
  logic            drain_s;

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [31:0]      main_instr_q, main_instr_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;

  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .instr_i   (bus.in_instr),
    .type_i    (bus.in_type),
    .imm_o     (new_imm_s),
    .illegal_o (new_ill_s)
  );

  // Upstream ready comes only from registered skid state.
  assign bus.in_ready    = ~skid_valid_q;
  assign accept_s        = bus.in_valid & ~skid_valid_q & ~flush;
  assign drain_s         = main_valid_q & bus.out_ready;

  assign bus.out_valid   = main_valid_q;
  assign bus.out_imm     = main_imm_q;
  assign bus.out_instr   = main_instr_q;
  assign bus.out_tag     = main_tag_q;
  assign bus.out_illegal = main_ill_q;

  // Buffer next state: flush clears, main refills from skid first, then from input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_instr_d = main_instr_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_instr_d = skid_instr_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain_s) begin
      if (skid_valid_q) begin
        // Skid is full so input is blocked; promote the older entry.
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_instr_d = skid_instr_q;
        main_tag_d   = skid_tag_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        main_valid_d = 1'b1;
        main_imm_d   = new_imm_s;
        main_instr_d = bus.in_instr;
        main_tag_d   = bus.in_tag;
        main_ill_d   = new_ill_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = new_imm_s;
      skid_instr_d = bus.in_instr;
      skid_tag_d   = bus.in_tag;
      skid_ill_d   = new_ill_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Buffer registers; reset zeroes data so outputs are defined immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= {XLEN{1'b0}};
      main_instr_q <= 32'd0;
      main_tag_q   <= {TAG_W{1'b0}};
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= {XLEN{1'b0}};
      skid_instr_q <= 32'd0;
      skid_tag_q   <= {TAG_W{1'b0}};
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_instr_q <= main_instr_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_instr_q <= skid_instr_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic mon_en  = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

  typedef struct {
    logic [63:0] imm;
    logic        ill;
    logic [31:0] instr;
    logic [31:0] tag;
    int          cyc;
  } item_t;

  item_t got_q[$];
  item_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every 32-bit transfer that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (mon_en && !rst && !flush && bus32.out_valid && bus32.out_ready) begin
      got_q.push_back('{imm: {32'd0, bus32.out_imm}, ill: bus32.out_illegal,
                        instr: bus32.out_instr, tag: bus32.out_tag, cyc: cyc});
    end
  end

  // Reference: immediate as a signed/unsigned integer built from the field layout.
  function automatic void model(input logic [31:0] ins, input logic [2:0] t, input int xlen,
                                output logic [63:0] imm, output logic ill);
    longint v;
    ill = 1'b0;
    case (t)
      IMM_I:  v = longint'($signed(ins[31:20]));
      IMM_S:  v = longint'($signed({ins[31:25], ins[11:7]}));
      IMM_B:  v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      IMM_U:  v = longint'($signed({ins[31:12], 12'h000}));
      IMM_J:  v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      IMM_Z:  v = longint'(ins[19:15]);
      IMM_SH: begin
        if (xlen == 32 && ins[25]) begin
          ill = 1'b1;
          v   = 0;
        end else begin
          v = longint'(ins[25:20]);
        end
      end
      default: v = 0;
    endcase
    imm = v;
    if (xlen == 32) imm[63:32] = 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] ins, input logic [2:0] t,
                         input logic [31:0] tag);
    bus32.in_valid = v;
    bus32.in_instr = ins;
    bus32.in_type  = t;
    bus32.in_tag   = tag;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_imm !== 32'd0 ||
        bus32.out_tag !== 32'd0 || bus32.out_instr !== 32'd0 || bus32.out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset32: valid=%b ready=%b imm=%h tag=%h instr=%h ill=%b, want 0 1 0 0 0 0",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_tag,
               bus32.out_instr, bus32.out_illegal);
    end
    n_tests++;
    if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1 || bus64.out_imm !== 64'd0) begin
      n_fail++;
      $display("FAIL reset64: valid=%b ready=%b imm=%h, want 0 1 0",
               bus64.out_valid, bus64.in_ready, bus64.out_imm);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_formats();
    logic [31:0] ins_t [8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h12345037,
                               32'h8000006F, 32'hDEADBEEF, 32'h000F8073, 32'h01F00013};
    logic [2:0]  typ_t [8] = '{IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R, IMM_Z, IMM_SH};
    logic [31:0] exp_t [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000,
                               32'hFFF00000, 32'h00000000, 32'h0000001F, 32'h0000001F};
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive32(1'b1, ins_t[i], typ_t[i], 32'h100 + i);
      tick();
      drive32(1'b0, 32'd0, 3'd0, 32'd0);
      n_tests++;
      if (bus32.out_valid !== 1'b1 || bus32.out_imm !== exp_t[i] || bus32.out_illegal !== 1'b0 ||
          bus32.out_tag !== 32'h100 + i || bus32.out_instr !== ins_t[i]) begin
        n_fail++;
        $display("FAIL fmt%0d: valid=%b imm=%h ill=%b tag=%h instr=%h, want 1 %h 0 %h %h",
                 i, bus32.out_valid, bus32.out_imm, bus32.out_illegal, bus32.out_tag,
                 bus32.out_instr, exp_t[i], 32'h100 + i, ins_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_xlen64();
    bus64.out_ready = 1'b1;
    bus64.in_valid  = 1'b1;
    bus64.in_instr  = 32'h80000037;
    bus64.in_type   = IMM_U;
    bus64.in_tag    = 32'h64;
    tick();
    n_tests++;
    if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'hFFFFFFFF80000000) begin
      n_fail++;
      $display("FAIL u64: valid=%b imm=%h, want 1 ffffffff80000000", bus64.out_valid, bus64.out_imm);
    end
    bus64.in_instr = 32'h03F00013;
    bus64.in_type  = IMM_SH;
    tick();
    bus64.in_valid = 1'b0;
    n_tests++;
    if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'h3F || bus64.out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL sh64: valid=%b imm=%h ill=%b, want 1 3f 0",
               bus64.out_valid, bus64.out_imm, bus64.out_illegal);
    end
    bus32.out_ready = 1'b1;
    drive32(1'b1, 32'h03F00013, IMM_SH, 32'h32);
    tick();
    drive32(1'b0, 32'd0, 3'd0, 32'd0);
    n_tests++;
    if (bus32.out_valid !== 1'b1 || bus32.out_imm !== 32'd0 || bus32.out_illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL sh32_illegal: valid=%b imm=%h ill=%b, want 1 0 1",
               bus32.out_valid, bus32.out_imm, bus32.out_illegal);
    end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [3];
    logic [2:0]  typ [3];
    logic [63:0] eimm;
    logic        eill;
    got_q.delete();
    mon_en = 1'b1;
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ins[i] = $urandom();
      typ[i] = 3'($urandom_range(4, 0));
    end
    model(ins[0], typ[0], 32, eimm, eill);
    drive32(1'b1, ins[0], typ[0], 32'd1);
    tick();
    drive32(1'b1, ins[1], typ[1], 32'd2);
    tick();
    n_tests++;
    if (bus32.in_ready !== 1'b0 || bus32.out_tag !== 32'd1) begin
      n_fail++;
      $display("FAIL bp_full: in_ready=%b tag=%h, want 0 1", bus32.in_ready, bus32.out_tag);
    end
    drive32(1'b1, ins[2], typ[2], 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1 || bus32.out_tag !== 32'd1 ||
          bus32.out_imm !== eimm[31:0] || bus32.out_instr !== ins[0]) begin
        n_fail++;
        $display("FAIL bp_hold%0d: ready=%b valid=%b tag=%h imm=%h, want 0 1 1 %h",
                 k, bus32.in_ready, bus32.out_valid, bus32.out_tag, bus32.out_imm, eimm[31:0]);
      end
    end
    bus32.out_ready = 1'b1;
    tick();
    tick();
    drive32(1'b0, 32'd0, 3'd0, 32'd0);
    for (int k = 0; k < 4; k++) tick();
    mon_en = 1'b0;
    n_tests++;
    if (got_q.size() !== 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        model(ins[i], typ[i], 32, eimm, eill);
        n_tests++;
        if (got_q[i].tag !== 32'(i + 1) || got_q[i].imm !== eimm || got_q[i].ill !== eill ||
            got_q[i].cyc !== got_q[0].cyc + i) begin
          n_fail++;
          $display("FAIL bp_out%0d: tag=%h imm=%h cyc=%0d, want %h %h %0d",
                   i, got_q[i].tag, got_q[i].imm, got_q[i].cyc, i + 1, eimm, got_q[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_streaming();
    logic [31:0] ins;
    logic [2:0]  typ;
    logic [63:0] eimm;
    logic        eill;
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ins = $urandom();
      typ = 3'($urandom_range(7, 0));
      model(ins, typ, 32, eimm, eill);
      exp_q.push_back('{imm: eimm, ill: eill, instr: ins, tag: 32'(1000 + i), cyc: 0});
      drive32(1'b1, ins, typ, 32'(1000 + i));
      n_tests++;
      if (bus32.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready%0d: in_ready=%b, want 1", i, bus32.in_ready);
      end
      tick();
      n_tests++;
      if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 32'(1000 + i)) begin
        n_fail++;
        $display("FAIL stream_lat%0d: valid=%b tag=%0d, want 1 %0d",
                 i, bus32.out_valid, bus32.out_tag, 1000 + i);
      end
    end
    drive32(1'b0, 32'd0, 3'd0, 32'd0);
    tick();
    tick();
    mon_en = 1'b0;
    n_tests++;
    if (got_q.size() !== 100) begin
      n_fail++;
      $display("FAIL stream_count: got %0d outputs, want 100", got_q.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        n_tests++;
        if (got_q[i].tag !== exp_q[i].tag || got_q[i].imm !== exp_q[i].imm ||
            got_q[i].ill !== exp_q[i].ill || got_q[i].instr !== exp_q[i].instr ||
            got_q[i].cyc !== got_q[0].cyc + i) begin
          n_fail++;
          $display("FAIL stream_out%0d: tag=%0d imm=%h ill=%b cyc=%0d, want %0d %h %b %0d",
                   i, got_q[i].tag, got_q[i].imm, got_q[i].ill, got_q[i].cyc,
                   exp_q[i].tag, exp_q[i].imm, exp_q[i].ill, got_q[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [2:0]  typ;
    logic [63:0] eimm;
    logic        eill;
    logic        hold;
    logic [31:0] s_imm, s_instr, s_tag;
    logic        s_ill;
    int          nacc = 0;
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ins = $urandom();
      typ = 3'($urandom_range(7, 0));
      drive32(1'($urandom_range(1, 0)), ins, typ, 32'(5000 + nacc));
      bus32.out_ready = ($urandom_range(2, 0) != 0);
      if (bus32.in_valid && bus32.in_ready) begin
        model(ins, typ, 32, eimm, eill);
        exp_q.push_back('{imm: eimm, ill: eill, instr: ins, tag: 32'(5000 + nacc), cyc: 0});
        nacc++;
      end
      hold    = bus32.out_valid && !bus32.out_ready;
      s_imm   = bus32.out_imm;
      s_instr = bus32.out_instr;
      s_tag   = bus32.out_tag;
      s_ill   = bus32.out_illegal;
      tick();
      if (hold) begin
        n_tests++;
        if (bus32.out_valid !== 1'b1 || bus32.out_imm !== s_imm || bus32.out_instr !== s_instr ||
            bus32.out_tag !== s_tag || bus32.out_illegal !== s_ill) begin
          n_fail++;
          $display("FAIL b2b_stable%0d: valid=%b imm=%h tag=%h, want 1 %h %h",
                   i, bus32.out_valid, bus32.out_imm, bus32.out_tag, s_imm, s_tag);
        end
      end
    end
    drive32(1'b0, 32'd0, 3'd0, 32'd0);
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    mon_en = 1'b0;
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs, want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (got_q[i].tag !== exp_q[i].tag || got_q[i].imm !== exp_q[i].imm ||
            got_q[i].ill !== exp_q[i].ill) begin
          n_fail++;
          $display("FAIL b2b_out%0d: tag=%0d imm=%h ill=%b, want %0d %h %b", i, got_q[i].tag,
                   got_q[i].imm, got_q[i].ill, exp_q[i].tag, exp_q[i].imm, exp_q[i].ill);
        end
      end
    end
  endtask

  task automatic test_flush();
    got_q.delete();
    mon_en = 1'b1;
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'hFFF00093, IMM_I, 32'hA1);
    tick();
    drive32(1'b1, 32'h12345037, IMM_U, 32'hA2);
    tick();
    drive32(1'b1, 32'h8000006F, IMM_J, 32'hA3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: valid=%b ready=%b, want 0 1", bus32.out_valid, bus32.in_ready);
    end
    drive32(1'b1, 32'hFE112E23, IMM_S, 32'hB1);
    tick();
    drive32(1'b1, 32'h000F8073, IMM_Z, 32'hB2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive32(1'b0, 32'd0, 3'd0, 32'd0);
    n_tests++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_accept: valid=%b ready=%b, want 0 1", bus32.out_valid, bus32.in_ready);
    end
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    drive32(1'b1, 32'h000F8073, IMM_Z, 32'hD0);
    tick();
    drive32(1'b0, 32'd0, 3'd0, 32'd0);
    tick();
    tick();
    mon_en = 1'b0;
    n_tests++;
    if (got_q.size() !== 1 || got_q[0].tag !== 32'hD0 || got_q[0].imm !== 64'h1F) begin
      n_fail++;
      $display("FAIL flush_after: got %0d outputs first tag=%h, want 1 d0",
               got_q.size(), (got_q.size() > 0) ? got_q[0].tag : 32'hFFFFFFFF);
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    mon_en = 1'b1;
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'hFFF00093, IMM_I, 32'hC1);
    tick();
    drive32(1'b1, 32'hFE112E23, IMM_S, 32'hC2);
    tick();
    drive32(1'b0, 32'd0, 3'd0, 32'd0);
    rst = 1'b1;
    #2;
    n_tests++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_imm !== 32'd0 ||
        bus32.out_tag !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ready=%b imm=%h tag=%h, want 0 1 0 0",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_tag);
    end
    tick();
    rst = 1'b0;
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    mon_en = 1'b0;
    n_tests++;
    if (got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_drop: got %0d outputs, want 0", got_q.size());
    end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drive32(1'b0, 32'd0, 3'd0, 32'd0);
    bus32.out_ready = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.in_instr  = 32'd0;
    bus64.in_type   = 3'd0;
    bus64.in_tag    = 32'd0;
    bus64.out_ready = 1'b0;
    test_reset();
    test_formats();
    test_xlen64();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
